// File: rtl/timekeeper_pkg.sv
// Shared encodings and limits for the alarm timekeeper: FSM states,
// counter wrap values and the 24h -> 12h display mapping.
package timekeeper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZED = 2'd2
   } tk_state_e;

   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [4:0] HOUR_MAX = 5'd23;

   // 0 shows as 12, 13..23 fold down to 1..11
   function automatic logic [4:0] hour_12h(input logic [4:0] h);
      logic [4:0] r;
      if (h == 5'd0)
         r = 5'd12;
      else if (h > 5'd12)
         r = h - 5'd12;
      else
         r = h;
      return r;
   endfunction

endpackage

// File: rtl/tk_bcd_split2.sv
// Two-digit binary to BCD split for values 0..99 (purely combinational).
module tk_bcd_split2 (
   input  logic [6:0] i_bin,
   output logic [3:0] o_tens,
   output logic [3:0] o_ones
);

   assign o_tens = 4'(i_bin / 7'd10);
   assign o_ones = 4'(i_bin % 7'd10);

endmodule

// File: rtl/multi_alarm_timekeeper.sv
// Seconds/minutes/hours timekeeper with N alarm slots, snooze and ring timeout.
// Time, slot storage and the ring FSM all live here; BCD display is combinational.
module multi_alarm_timekeeper
   import timekeeper_pkg::*;
#(
   parameter  int TICKS_PER_SEC  = 1000000,
   parameter  int N_ALARMS       = 4,
   parameter  int SNOOZE_MIN     = 5,
   parameter  int MAX_SNOOZE     = 3,
   parameter  int RING_TIMEOUT_S = 60,
   localparam int IDX_W          = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_min_inc,
   input  logic             i_hour_inc,
   input  logic             i_mode_12h,
   input  logic             i_alm_wr,
   input  logic [IDX_W-1:0] i_alm_idx,
   input  logic [4:0]       i_alm_hour,
   input  logic [5:0]       i_alm_min,
   input  logic             i_alm_en,
   input  logic             i_snooze,
   input  logic             i_dismiss,
   output logic [5:0]       o_sec,
   output logic [5:0]       o_min,
   output logic [4:0]       o_hour,
   output logic [3:0]       o_h10,
   output logic [3:0]       o_h1,
   output logic [3:0]       o_m10,
   output logic [3:0]       o_m1,
   output logic [3:0]       o_s10,
   output logic [3:0]       o_s1,
   output logic             o_pm,
   output logic             o_sec_tick,
   output logic             o_alarm,
   output logic [IDX_W-1:0] o_alarm_slot,
   output logic             o_alm_err
);

   localparam int CNT_W = $clog2(TICKS_PER_SEC);
   localparam int SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICKS_PER_SEC - 1);
   localparam logic [SNZ_W-1:0] SNZ_LIMIT  = SNZ_W'(MAX_SNOOZE);
   localparam logic [11:0]      SNOOZE_SEC = 12'(SNOOZE_MIN * 60);
   localparam logic [15:0]      RING_LAST  = 16'(RING_TIMEOUT_S - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [5:0]       r_sec;
   logic [5:0]       r_min;
   logic [4:0]       r_hour;
   logic             r_sec_tick;

   logic [4:0]          r_alm_hour [N_ALARMS];
   logic [5:0]          r_alm_min  [N_ALARMS];
   logic [N_ALARMS-1:0] r_alm_en;
   logic                r_alm_err;

   tk_state_e        r_state;
   logic             r_alarm;
   logic [IDX_W-1:0] r_alarm_slot;
   logic [SNZ_W-1:0] r_snooze_cnt;
   logic [15:0]      r_ring_sec;
   logic [11:0]      r_wait_sec;

   logic             w_tick;
   logic             w_sec_wrap;
   logic             w_min_step;
   logic             w_hour_step;
   logic             w_wr_ok;
   logic             w_any_match;
   logic             w_hit;
   logic [IDX_W-1:0] w_win;
   logic [4:0]       w_hour_disp;

   // A coincident manual and carry increment collapse into a single step
   assign w_tick      = (r_cnt == CNT_LAST);
   assign w_sec_wrap  = w_tick && (r_sec == SEC_MAX);
   assign w_min_step  = w_sec_wrap || i_min_inc;
   assign w_hour_step = (w_sec_wrap && (r_min == MIN_MAX)) || i_hour_inc;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt      <= '0;
         r_sec      <= '0;
         r_min      <= '0;
         r_hour     <= '0;
         r_sec_tick <= 1'b0;
      end else begin
         r_sec_tick <= w_tick;
         if (w_tick) begin
            r_cnt <= '0;
            r_sec <= (r_sec == SEC_MAX) ? 6'd0 : r_sec + 6'd1;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_min_step)
            r_min <= (r_min == MIN_MAX) ? 6'd0 : r_min + 6'd1;
         if (w_hour_step)
            r_hour <= (r_hour == HOUR_MAX) ? 5'd0 : r_hour + 5'd1;
      end
   end

   assign w_wr_ok = (i_alm_hour <= HOUR_MAX) && (i_alm_min <= MIN_MAX) &&
                    (int'({1'b0, i_alm_idx}) < N_ALARMS);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int k = 0; k < N_ALARMS; k++) begin
            r_alm_hour[k] <= '0;
            r_alm_min[k]  <= '0;
         end
         r_alm_en  <= '0;
         r_alm_err <= 1'b0;
      end else begin
         r_alm_err <= i_alm_wr && !w_wr_ok;
         for (int k = 0; k < N_ALARMS; k++) begin
            if (i_alm_wr && w_wr_ok && (i_alm_idx == IDX_W'(k))) begin
               r_alm_hour[k] <= i_alm_hour;
               r_alm_min[k]  <= i_alm_min;
               r_alm_en[k]   <= i_alm_en;
            end
         end
      end
   end

   // Descending scan so the lowest matching index is the one left standing
   always_comb begin
      w_any_match = 1'b0;
      w_win       = '0;
      for (int k = N_ALARMS - 1; k >= 0; k--) begin
         if (r_alm_en[k] && (r_alm_hour[k] == r_hour) && (r_alm_min[k] == r_min)) begin
            w_any_match = 1'b1;
            w_win       = IDX_W'(k);
         end
      end
   end

   // SEC only returns to 0 through a tick, so this excludes manual MIN/HOUR edits
   assign w_hit = w_any_match && r_sec_tick && (r_sec == 6'd0);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_alarm      <= 1'b0;
         r_alarm_slot <= '0;
         r_snooze_cnt <= '0;
         r_ring_sec   <= '0;
         r_wait_sec   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hit) begin
                  r_state      <= ST_RINGING;
                  r_alarm      <= 1'b1;
                  r_alarm_slot <= w_win;
                  r_snooze_cnt <= '0;
                  r_ring_sec   <= '0;
               end
            end
            ST_RINGING: begin
               if (i_dismiss) begin
                  r_state <= ST_IDLE;
                  r_alarm <= 1'b0;
               end else if (i_snooze && (r_snooze_cnt < SNZ_LIMIT)) begin
                  r_state      <= ST_SNOOZED;
                  r_alarm      <= 1'b0;
                  r_snooze_cnt <= r_snooze_cnt + SNZ_W'(1);
                  r_wait_sec   <= SNOOZE_SEC;
               end else if ((RING_TIMEOUT_S != 0) && r_sec_tick) begin
                  if (r_ring_sec == RING_LAST) begin
                     r_state <= ST_IDLE;
                     r_alarm <= 1'b0;
                  end else begin
                     r_ring_sec <= r_ring_sec + 16'd1;
                  end
               end
            end
            ST_SNOOZED: begin
               if (i_dismiss) begin
                  r_state <= ST_IDLE;
                  r_alarm <= 1'b0;
               end else if (r_sec_tick) begin
                  if (r_wait_sec <= 12'd1) begin
                     r_state    <= ST_RINGING;
                     r_alarm    <= 1'b1;
                     r_ring_sec <= '0;
                  end else begin
                     r_wait_sec <= r_wait_sec - 12'd1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_alarm <= 1'b0;
            end
         endcase
      end
   end

   assign w_hour_disp = i_mode_12h ? hour_12h(r_hour) : r_hour;

   tk_bcd_split2 u_bcd_hour (.i_bin({2'b00, w_hour_disp}), .o_tens(o_h10), .o_ones(o_h1));
   tk_bcd_split2 u_bcd_min  (.i_bin({1'b0, r_min}),        .o_tens(o_m10), .o_ones(o_m1));
   tk_bcd_split2 u_bcd_sec  (.i_bin({1'b0, r_sec}),        .o_tens(o_s10), .o_ones(o_s1));

   assign o_sec        = r_sec;
   assign o_min        = r_min;
   assign o_hour       = r_hour;
   assign o_pm         = (r_hour >= 5'd12);
   assign o_sec_tick   = r_sec_tick;
   assign o_alarm      = r_alarm;
   assign o_alarm_slot = r_alarm_slot;
   assign o_alm_err    = r_alm_err;

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// Directed scoreboard bench for multi_alarm_timekeeper at 4 clocks per second.
module tb_multi_alarm_timekeeper;

   logic       clk = 1'b0;
   logic       i_reset, i_min_inc, i_hour_inc, i_mode_12h, i_alm_wr, i_alm_en, i_snooze, i_dismiss;
   logic [1:0] i_alm_idx;
   logic [4:0] i_alm_hour;
   logic [5:0] i_alm_min;
   logic [5:0] o_sec, o_min;
   logic [4:0] o_hour;
   logic [3:0] o_h10, o_h1, o_m10, o_m1, o_s10, o_s1;
   logic       o_pm, o_sec_tick, o_alarm, o_alm_err;
   logic [1:0] o_alarm_slot;

   int errors = 0, checks = 0;
   int found, seen_alarm, tcnt, bits;
   string tag_q[$];
   int    exp_q[$];

   always #5 clk = ~clk;

   multi_alarm_timekeeper #(
      .TICKS_PER_SEC(4), .N_ALARMS(4), .SNOOZE_MIN(1), .MAX_SNOOZE(3), .RING_TIMEOUT_S(5)
   ) dut (
      .i_clk(clk), .i_reset(i_reset), .i_min_inc(i_min_inc), .i_hour_inc(i_hour_inc),
      .i_mode_12h(i_mode_12h), .i_alm_wr(i_alm_wr), .i_alm_idx(i_alm_idx),
      .i_alm_hour(i_alm_hour), .i_alm_min(i_alm_min), .i_alm_en(i_alm_en),
      .i_snooze(i_snooze), .i_dismiss(i_dismiss),
      .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
      .o_h10(o_h10), .o_h1(o_h1), .o_m10(o_m10), .o_m1(o_m1), .o_s10(o_s10), .o_s1(o_s1),
      .o_pm(o_pm), .o_sec_tick(o_sec_tick), .o_alarm(o_alarm),
      .o_alarm_slot(o_alarm_slot), .o_alm_err(o_alm_err)
   );

   task automatic step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (o_alarm) seen_alarm = 1;
      end
   endtask

   task automatic push(string t, int v);
      tag_q.push_back(t);
      exp_q.push_back(v);
   endtask

   task automatic pop_chk(int obs);
      string t;
      int    e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL sb_empty: got %0d with no expected value queued", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", t, obs, e);
         end
      end
   endtask

   function automatic int digits();
      return int'({o_h10, o_h1, o_m10, o_m1, o_s10, o_s1});
   endfunction

   function automatic int hms();
      return int'(o_hour) * 10000 + int'(o_min) * 100 + int'(o_sec);
   endfunction

   task automatic wait_time(int h, int m, int s, int budget);
      found = 0;
      for (int i = 0; i < budget; i++) begin
         if (int'(o_hour) == h && int'(o_min) == m && int'(o_sec) == s) begin
            found = 1;
            break;
         end
         step(1);
      end
   endtask

   task automatic wait_sec(int s, int budget);
      found = 0;
      for (int i = 0; i < budget; i++) begin
         if (int'(o_sec) == s) begin
            found = 1;
            break;
         end
         step(1);
      end
   endtask

   // counts SEC_TICK cycles until ALARM reaches the given level
   task automatic count_ticks(int until_lvl, int budget);
      tcnt = 0;
      for (int i = 0; i < budget; i++) begin
         if (int'(o_alarm) == until_lvl) break;
         if (o_sec_tick) tcnt++;
         step(1);
      end
   endtask

   task automatic write_slot(int idx, int h, int m, int en);
      i_alm_idx  = 2'(idx);
      i_alm_hour = 5'(h);
      i_alm_min  = 6'(m);
      i_alm_en   = en[0];
      i_alm_wr   = 1'b1;
      step(1);
      i_alm_wr   = 1'b0;
   endtask

   initial begin
      i_reset = 1'b1; i_min_inc = 1'b0; i_hour_inc = 1'b0; i_mode_12h = 1'b0;
      i_alm_wr = 1'b0; i_alm_en = 1'b0; i_snooze = 1'b0; i_dismiss = 1'b0;
      i_alm_idx = '0; i_alm_hour = '0; i_alm_min = '0;
      seen_alarm = 0;

      // reset state
      step(2);
      push("rst_time", 0);      pop_chk(hms());
      push("rst_digits24", 0);  pop_chk(digits());
      push("rst_alarm", 0);     pop_chk(int'(o_alarm));
      push("rst_slot", 0);      pop_chk(int'(o_alarm_slot));
      push("rst_tick", 0);      pop_chk(int'(o_sec_tick));
      push("rst_err", 0);       pop_chk(int'(o_alm_err));
      push("rst_pm", 0);        pop_chk(int'(o_pm));
      i_mode_12h = 1'b1;
      #1;
      push("rst_digits12", 'h120000); pop_chk(digits());
      i_reset = 1'b0;

      // SEC_TICK cadence: high every 4th cycle
      for (int r = 1; r <= 2; r++) begin
         bits = 0;
         for (int i = 0; i < 4; i++) begin
            step(1);
            bits |= int'(o_sec_tick) << i;
         end
         push("tick_pattern", 8); pop_chk(bits);
         push("tick_sec", r);     pop_chk(int'(o_sec));
      end

      // noon rollover and PM
      i_hour_inc = 1'b1; step(11); i_hour_inc = 1'b0;
      i_min_inc  = 1'b1; step(59); i_min_inc  = 1'b0;
      push("pm_before_noon", 0); pop_chk(int'(o_pm));
      wait_time(12, 0, 0, 400);
      push("reach_noon", 1);      pop_chk(found);
      push("pm_noon", 1);         pop_chk(int'(o_pm));
      push("noon_digits12", 'h120000); pop_chk(digits());

      // day wrap
      i_hour_inc = 1'b1; step(11); i_hour_inc = 1'b0;
      i_min_inc  = 1'b1; step(59); i_min_inc  = 1'b0;
      wait_time(23, 59, 59, 400);
      push("reach_235959", 1);        pop_chk(found);
      push("digits12_2359", 'h115959); pop_chk(digits());
      push("pm_2359", 1);             pop_chk(int'(o_pm));
      step(1);
      wait_time(0, 0, 0, 8);
      push("wrap_midnight", 1);       pop_chk(found);
      push("pm_midnight", 0);         pop_chk(int'(o_pm));
      push("digits12_0000", 'h120000); pop_chk(digits());
      i_mode_12h = 1'b0;
      #1;
      push("digits24_0000", 0);       pop_chk(digits());

      // MIN_INC coincident with the hour carry advances MIN once
      i_min_inc = 1'b1; step(59); i_min_inc = 1'b0;
      wait_time(0, 59, 59, 400);
      push("reach_005959", 1); pop_chk(found);
      step(3);
      i_min_inc = 1'b1; step(1); i_min_inc = 1'b0;
      push("inc_on_carry", 10000); pop_chk(hms());

      // MIN_INC at xx:59 wraps without carry into HOUR
      i_min_inc = 1'b1; step(59); i_min_inc = 1'b0;
      wait_time(1, 59, 20, 200);
      push("reach_015920", 1); pop_chk(found);
      i_min_inc = 1'b1; step(1); i_min_inc = 1'b0;
      push("min_wrap_nocarry", 10020); pop_chk(hms());

      // two enabled slots at 07:30, lowest index wins
      write_slot(0, 7, 30, 0);
      push("wr_ok_err", 0); pop_chk(int'(o_alm_err));
      write_slot(1, 7, 30, 1);
      write_slot(2, 7, 30, 1);
      i_hour_inc = 1'b1; step(6);  i_hour_inc = 1'b0;
      i_min_inc  = 1'b1; step(29); i_min_inc  = 1'b0;
      wait_time(7, 30, 0, 400);
      push("reach_0730", 1);   pop_chk(found);
      push("alarm_at_0730", 0); pop_chk(int'(o_alarm));
      step(1);
      push("alarm_next", 1);   pop_chk(int'(o_alarm));
      push("alarm_slot", 1);   pop_chk(int'(o_alarm_slot));

      // three snoozes of 60 SEC_TICKs, fourth ignored, then dismiss
      for (int r = 0; r < 3; r++) begin
         i_snooze = 1'b1; step(1); i_snooze = 1'b0;
         push("snooze_off", 0);  pop_chk(int'(o_alarm));
         count_ticks(1, 400);
         push("snooze_ticks", 60); pop_chk(tcnt);
      end
      i_snooze = 1'b1; step(1); i_snooze = 1'b0;
      push("snooze4_ignored", 1); pop_chk(int'(o_alarm));
      i_dismiss = 1'b1; step(1); i_dismiss = 1'b0;
      push("dismiss_off", 0); pop_chk(int'(o_alarm));
      seen_alarm = 0; step(8);
      push("dismiss_stays", 0); pop_chk(seen_alarm);

      // reaching 07:30 by MIN_INC must not ring
      wait_sec(5, 300);
      push("reach_sec5", 1); pop_chk(found);
      i_min_inc = 1'b1;
      for (int i = 0; i < 70; i++) begin
         if (o_min == 6'd30) break;
         step(1);
      end
      i_min_inc = 1'b0;
      push("manual_0730", 730); pop_chk(int'(o_hour) * 100 + int'(o_min));
      seen_alarm = 0; step(40);
      push("manual_no_ring", 0); pop_chk(seen_alarm);

      // ring timeout after 5 SEC_TICKs
      write_slot(0, 7, 31, 1);
      wait_time(7, 31, 0, 400);
      push("reach_0731", 1); pop_chk(found);
      step(1);
      push("ring_0731", 1);  pop_chk(int'(o_alarm));
      push("slot_0731", 0);  pop_chk(int'(o_alarm_slot));
      count_ticks(0, 100);
      push("timeout_ticks", 5); pop_chk(tcnt);

      // SNOOZE and DISMISS together: dismiss wins, no re-ring
      write_slot(0, 7, 32, 1);
      wait_time(7, 32, 0, 400);
      push("reach_0732", 1); pop_chk(found);
      step(1);
      push("ring_0732", 1);  pop_chk(int'(o_alarm));
      i_snooze = 1'b1; i_dismiss = 1'b1; step(1); i_snooze = 1'b0; i_dismiss = 1'b0;
      push("both_off", 0);   pop_chk(int'(o_alarm));
      seen_alarm = 0; step(280);
      push("both_idle", 0);  pop_chk(seen_alarm);

      // rejected writes leave the slot intact
      write_slot(0, 7, 35, 1);
      push("wr_ok2_err", 0); pop_chk(int'(o_alm_err));
      write_slot(0, 24, 35, 0);
      push("err_hour24", 1); pop_chk(int'(o_alm_err));
      step(1);
      push("err_pulse_end", 0); pop_chk(int'(o_alm_err));
      write_slot(0, 7, 60, 0);
      push("err_min60", 1);  pop_chk(int'(o_alm_err));
      write_slot(3, 0, 1, 1);
      wait_time(7, 35, 0, 800);
      push("reach_0735", 1); pop_chk(found);
      step(1);
      push("slot_kept_ring", 1); pop_chk(int'(o_alarm));
      push("slot_kept_idx", 0);  pop_chk(int'(o_alarm_slot));

      // reset while ringing clears the alarm and disables every slot
      i_reset = 1'b1; step(1); i_reset = 1'b0;
      push("rst_ring_alarm", 0); pop_chk(int'(o_alarm));
      push("rst_ring_time", 0);  pop_chk(hms());
      seen_alarm = 0;
      wait_time(0, 1, 5, 400);
      push("reach_000105", 1);   pop_chk(found);
      push("slots_disabled", 0); pop_chk(seen_alarm);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
